fir_axi_lite_master: RTL and testbench
======================================

Name: fir_axi_lite_master

Overview:
- AXI4-Lite initiator that drives the FIR coefficient/histogram register slave from fabric-side logic, e.g. a power-up coefficient loader or a histogram dump engine.
- Accepts one single-beat command at a time on a simple valid/ready command port.
- Runs the matching AXI4-Lite write (AW+W→B) or read (AR→R) transaction.
- Returns the response on a valid/ready response port. Includes a watchdog that flags a stalled slave.

Parameters:
C_M_AXI_DATA_WIDTH, 32, data width of WDATA/RDATA and of the command/response data
C_M_AXI_ADDR_WIDTH, 8, address width of AWADDR/ARADDR and of cmd_addr
TIMEOUT_CYCLES, 1024, cycles spent waiting in one transaction before timeout_o is asserted; 0 disables the watchdog

Ports:
m_axi_aclk  in  1  single clock for the whole block
m_axi_aresetn  in  1  synchronous, active-high reset (port keeps the codebase name; polarity is active-high)
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP as returned by the slave
rsp_write  out  1  echo of cmd_write for this response
timeout_o  out  1  sticky watchdog flag
m_axi_awaddr  out  ADDR_W
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_W
m_axi_wstrb  out  DATA_W/8
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR_W
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  DATA_W
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset: state=IDLE, all VALID/READY outputs 0, rsp_rdata=0, rsp_resp=0, rsp_write=0, timeout_o=0, watchdog counter=0, addr/data/strobe registers=0.
- Reset asserted mid-transaction aborts it on the next edge; there is no recovery handshake.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/wdata/wstrb/write.
  - Write: assert awvalid and wvalid together on the next cycle, go to WR_REQ.
  - Read: assert arvalid, go to RD_REQ.
  - Command accepted → first VALID at the AXI pins after 1 cycle.
- WR_REQ:
  - awvalid drops on the cycle after the awready handshake; wvalid drops independently after the wready handshake.
  - AW and W may complete in either order or in the same cycle.
  - Once both are done → WR_RESP with bready=1.
  - VALID never drops before its handshake; addr/data/strb stay stable while VALID.
- WR_RESP: on bvalid, capture bresp, rsp_rdata=0, bready drops, go to RSP.
- RD_REQ: on arready, arvalid drops, rready=1, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata/rresp, rready drops, go to RSP.
- RSP:
  - rsp_valid=1, held with stable data until rsp_ready; then → IDLE.
  - cmd_ready stays 0, so back-to-back commands are spaced by at least 1 IDLE cycle.
- bready/rready are asserted only in WR_RESP/RD_DATA. An early bvalid/rvalid waits for them; no response is ever dropped.
- Watchdog:
  - Counter clears on entering WR_REQ/RD_REQ and counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - Reaching TIMEOUT_CYCLES sets timeout_o and saturates the counter.
  - timeout_o stays set until reset. The FSM keeps waiting, because AXI forbids abandoning a transaction.
- SLVERR/DECERR are passed through on rsp_resp unchanged; they do not set timeout_o.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF, wstrb=0xF; slave takes AW and W in the same cycle, bvalid 2 cycles later with OKAY → one AW and one W handshake with those values, then rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Write with awready delayed 5 cycles and wready immediate → wvalid drops after its handshake, awvalid held stable until cycle 5, exactly one B consumed.
- Read addr=0x24; slave returns rdata=0x00000123, rresp=2'b10 after 3 cycles → rsp_rdata=0x123, rsp_resp=2'b10, rsp_write=0.
- rsp_ready held 0 for 4 cycles → rsp_valid and data stable, cmd_ready=0 throughout; the next command is accepted only after the response handshake.
- Slave never returns bvalid, with TIMEOUT_CYCLES=16 → timeout_o rises exactly 16 cycles after entering WR_REQ and bready stays 1; a late bvalid still completes the response.
- Reset pulse while in RD_DATA → all outputs return to reset values the next cycle, and a following read completes normally.

Source files
------------

// File: rtl/fir_axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// A sticky watchdog flags a slave that stalls a transaction for TIMEOUT_CYCLES or more.
module fir_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_write,
  output logic                              timeout_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                    state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]              wd_cnt;
  logic                          waiting;
  logic                          aw_done;
  logic                          w_done;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // Reset is asserted-high on this port despite its name; no command is taken while it is held.
  assign cmd_ready = (state == S_IDLE) && !m_axi_aresetn;

  assign waiting = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                   (state == S_RD_REQ) || (state == S_RD_DATA);

  // A channel is finished once its VALID is already low or its handshake completes this cycle.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_aresetn) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_write     <= 1'b0;
      timeout_o     <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      if (TIMEOUT_CYCLES != 0 && waiting && wd_cnt != CNT_LIMIT) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
        if (wd_cnt + CNT_W'(1) == CNT_LIMIT) timeout_o <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            m_axi_wdata <= cmd_wdata;
            m_axi_wstrb <= cmd_wstrb;
            wd_cnt      <= '0;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= S_WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            m_axi_bready <= 1'b0;
            state        <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            m_axi_rready <= 1'b0;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_axi_lite_master.sv
// Directed bench for fir_axi_lite_master: a configurable AXI4-Lite slave model plus a
// scoreboard monitor that pops expected AW/W/AR beats and responses as the DUT presents them.
`timescale 1ns/1ps
module tb_fir_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  typedef struct packed {
    logic          write;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wbeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, timeout_o;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  fir_axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_write    (rsp_write),
    .timeout_o    (timeout_o),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  // Scoreboard queues, filled by the stimulus and drained by the monitor.
  logic [AW-1:0] exp_aw[$];
  logic [AW-1:0] exp_ar[$];
  wbeat_t        exp_w[$];
  rsp_t          exp_rsp[$];

  int n_vec = 0;
  int n_err = 0;

  // Slave model configuration.
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  bit         b_hold = 1'b0;

  // Handshakes seen at a negedge complete on the following posedge.
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  initial begin : slave
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      end else begin
        if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin m_axi_awready = 1'b0; aw_cnt = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_delay); w_cnt++; end
        else begin m_axi_wready = 1'b0; w_cnt = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin m_axi_arready = 1'b0; ar_cnt = 0; end

        if (m_axi_bvalid) begin
          if (b_hs) begin m_axi_bvalid = 1'b0; b_cnt = 0; end
        end else if (!b_hold && n_aw > n_b && n_w > n_b) begin
          if (b_cnt >= b_delay) begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; end
          else b_cnt++;
        end

        if (m_axi_rvalid) begin
          if (r_hs) begin m_axi_rvalid = 1'b0; r_cnt = 0; end
        end else if (n_ar > n_r) begin
          if (r_cnt >= r_delay) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg;
          end else r_cnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_rspv, p_rsphs;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    rsp_t          p_rsp;
    p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0; p_rspv = 0; p_rsphs = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_rsp = '0;
    forever begin
      @(negedge clk);
      aw_hs = !rst && m_axi_awvalid && m_axi_awready;
      w_hs  = !rst && m_axi_wvalid  && m_axi_wready;
      b_hs  = !rst && m_axi_bvalid  && m_axi_bready;
      ar_hs = !rst && m_axi_arvalid && m_axi_arready;
      r_hs  = !rst && m_axi_rvalid  && m_axi_rready;
      if (!rst) begin
        // VALID must persist with stable payload until its handshake.
        if (p_awv && !p_awhs) check("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_whs)   check("w_hold",  {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wdata});
        if (p_arv && !p_arhs) check("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
        if (p_rspv && !p_rsphs)
          check("rsp_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, p_rsp});

        if (aw_hs) begin
          n_aw++;
          if (exp_aw.size() == 0) check("aw_unexpected", {1'b1, m_axi_awaddr}, '0);
          else check("awaddr", m_axi_awaddr, exp_aw.pop_front());
        end
        if (w_hs) begin
          n_w++;
          if (exp_w.size() == 0) check("w_unexpected", {1'b1, m_axi_wdata}, '0);
          else check("wdata_wstrb", {m_axi_wdata, m_axi_wstrb}, exp_w.pop_front());
        end
        if (b_hs) n_b++;
        if (ar_hs) begin
          n_ar++;
          if (exp_ar.size() == 0) check("ar_unexpected", {1'b1, m_axi_araddr}, '0);
          else check("araddr", m_axi_araddr, exp_ar.pop_front());
        end
        if (r_hs) n_r++;
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) check("rsp_unexpected", {1'b1, rsp_write, rsp_resp, rsp_rdata}, '0);
          else check("rsp", {rsp_write, rsp_resp, rsp_rdata}, exp_rsp.pop_front());
        end
      end
      p_awv = !rst && m_axi_awvalid; p_awhs = aw_hs; p_awaddr = m_axi_awaddr;
      p_wv  = !rst && m_axi_wvalid;  p_whs  = w_hs;  p_wdata  = m_axi_wdata;
      p_arv = !rst && m_axi_arvalid; p_arhs = ar_hs; p_araddr = m_axi_araddr;
      p_rspv = !rst && rsp_valid; p_rsphs = rsp_valid && rsp_ready;
      p_rsp = {rsp_write, rsp_resp, rsp_rdata};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_rsp.size() != 0 && t < budget) begin @(negedge clk); t++; end
    check("rsp_drain_pending", exp_rsp.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d vectors, expected completion", n_vec);
    $fatal(1, "global timeout");
  end

  // ---------------- directed tests ----------------
  initial begin : stim
    int t;
    int b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_handshake_outs",
          {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
           rsp_valid, timeout_o}, 8'h00);
    check("rst_rsp_regs", {rsp_write, rsp_resp, rsp_rdata}, 0);
    check("rst_axi_regs", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // 1: write, AW and W accepted together, B two cycles later.
    aw_delay = 0; w_delay = 0; b_delay = 2; bresp_cfg = 2'b00;
    exp_aw.push_back(8'h10);
    exp_w.push_back({32'hDEADBEEF, 4'hF});
    exp_rsp.push_back({1'b1, 2'b00, 32'h0});
    b0 = n_b;
    drive_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    wait_accept();
    wait_drain(50);
    check("t1_b_count", n_b - b0, 1);

    // 2: awready late by 5 cycles, wready immediate.
    aw_delay = 5; w_delay = 0; b_delay = 0;
    exp_aw.push_back(8'h14);
    exp_w.push_back({32'h01020304, 4'h3});
    exp_rsp.push_back({1'b1, 2'b00, 32'h0});
    b0 = n_b;
    drive_cmd(1'b1, 8'h14, 32'h01020304, 4'h3);
    wait_accept();
    @(negedge clk);
    @(negedge clk);
    check("t2_w_done_aw_held", {m_axi_wvalid, m_axi_awvalid}, 2'b01);
    wait_drain(50);
    repeat (3) @(negedge clk);
    check("t2_b_count", n_b - b0, 1);
    @(posedge clk); #1;

    // 3: read with SLVERR after 3 cycles.
    aw_delay = 0; ar_delay = 0; r_delay = 3; rdata_cfg = 32'h00000123; rresp_cfg = 2'b10;
    exp_ar.push_back(8'h24);
    exp_rsp.push_back({1'b0, 2'b10, 32'h00000123});
    drive_cmd(1'b0, 8'h24, 32'h0, 4'h0);
    wait_accept();
    wait_drain(50);
    check("t3_no_timeout", timeout_o, 0);

    // 4: response back-pressure; next command waits behind it.
    rsp_ready = 1'b0; r_delay = 0; rdata_cfg = 32'h55AA0F0F; rresp_cfg = 2'b00;
    exp_ar.push_back(8'h30);
    exp_rsp.push_back({1'b0, 2'b00, 32'h55AA0F0F});
    drive_cmd(1'b0, 8'h30, 32'h0, 4'h0);
    wait_accept();
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    check("t4_rsp_valid_seen", rsp_valid, 1);
    @(posedge clk); #1;
    exp_aw.push_back(8'h40);
    exp_w.push_back({32'hA5A55A5A, 4'hC});
    exp_rsp.push_back({1'b1, 2'b00, 32'h0});
    drive_cmd(1'b1, 8'h40, 32'hA5A55A5A, 4'hC);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_rsp_stall", {rsp_valid, cmd_ready, m_axi_awvalid, rsp_rdata},
            {1'b1, 1'b0, 1'b0, 32'h55AA0F0F});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept();
    wait_drain(50);

    // 5: slave withholds B; watchdog fires 16 cycles after entering WR_REQ.
    b_hold = 1'b1; b_delay = 0; bresp_cfg = 2'b11;
    exp_aw.push_back(8'h50);
    exp_w.push_back({32'h0BADF00D, 4'hF});
    exp_rsp.push_back({1'b1, 2'b11, 32'h0});
    drive_cmd(1'b1, 8'h50, 32'h0BADF00D, 4'hF);
    wait_accept();
    @(negedge clk);
    check("t5_to_at_entry", timeout_o, 0);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == TO - 1) check("t5_to_cycle15", timeout_o, 0);
      if (k == TO) check("t5_to_cycle16", {timeout_o, m_axi_bready}, 2'b11);
    end
    repeat (5) @(negedge clk);
    check("t5_to_sticky_bready", {timeout_o, m_axi_bready}, 2'b11);
    @(posedge clk); #1;
    b_hold = 1'b0;
    wait_drain(50);
    check("t5_to_after_rsp", timeout_o, 1);

    // 6: reset while waiting for R, then a clean read.
    r_delay = 10; rdata_cfg = 32'hFFFF0000; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
    exp_ar.push_back(8'h60);
    drive_cmd(1'b0, 8'h60, 32'h0, 4'h0);
    wait_accept();
    t = 0;
    @(negedge clk);
    while (!m_axi_rready && t < 20) begin @(negedge clk); t++; end
    check("t6_in_rd_data", m_axi_rready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_handshake_outs",
          {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
           rsp_valid, timeout_o}, 8'h00);
    check("t6_rst_regs", {rsp_write, rsp_resp, rsp_rdata, m_axi_araddr, m_axi_wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    r_delay = 2; rdata_cfg = 32'hCAFE0001; rresp_cfg = 2'b00;
    exp_ar.push_back(8'h64);
    exp_rsp.push_back({1'b0, 2'b00, 32'hCAFE0001});
    drive_cmd(1'b0, 8'h64, 32'h0, 4'h0);
    wait_accept();
    wait_drain(50);
    check("t6_timeout_clear", timeout_o, 0);

    repeat (4) @(negedge clk);
    check("leftover_aw", exp_aw.size(), 0);
    check("leftover_w", exp_w.size(), 0);
    check("leftover_ar", exp_ar.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
